gpu_data_mem_responder: RTL and testbench
=========================================

Name: gpu_data_mem_responder

Overview:
Memory-side responder for the per-thread data-memory channels driven by a core's LSUs. It serves NUM_CONSUMERS read and write channels (valid/address/data in, ready/data out) against an internal single-port word array. Requests are taken one at a time in round-robin order, and the array access has a configurable latency. It stands in for the global data memory plus controller in core-level benches, and serves as the on-chip scratch memory for a single-core build.

Parameters:
NUM_CONSUMERS, 4, number of LSU channels (equals THREADS_PER_BLOCK)
ADDR_BITS, 8, word address width; array depth is 2**ADDR_BITS
DATA_BITS, 8, word width
MEM_LATENCY, 2, cycles spent in BUSY per access; legal range 1..15

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-low reset
read_valid  in  [NUM_CONSUMERS]  per-consumer read request
read_address  in  [NUM_CONSUMERS][ADDR_BITS]  read address
read_ready  out  [NUM_CONSUMERS]  read data valid; held until read_valid drops
read_data  out  [NUM_CONSUMERS][DATA_BITS]  returned word, registered per consumer
write_valid  in  [NUM_CONSUMERS]  per-consumer write request
write_address  in  [NUM_CONSUMERS][ADDR_BITS]  write address
write_data  in  [NUM_CONSUMERS][DATA_BITS]  write word
write_ready  out  [NUM_CONSUMERS]  write-done acknowledge; held until write_valid drops
init_we  in  1  backdoor preload write enable
init_addr  in  ADDR_BITS  preload address
init_data  in  DATA_BITS  preload word
busy  out  1  high whenever the FSM is not in IDLE

Behaviour:
- Reset (reset low, asynchronous):
  - FSM goes to IDLE; rr_ptr=0.
  - All read_ready and write_ready=0; all read_data=0; busy=0.
  - Array contents are not reset and survive a reset taken mid-operation.
  - An access that is in flight at reset is abandoned; a pending write is not committed.
- Pending: consumer i is pending when read_valid[i] or write_valid[i] is high and neither of its ready bits is high.
- FSM states: IDLE, BUSY, RELAY.
- IDLE:
  - Search from rr_ptr upward with wrap-around for the first pending consumer g.
  - Latch g, the operation, the address and the write data. If both read and write are valid for g, read is chosen.
  - Set cnt=MEM_LATENCY-1, then go to BUSY. With nothing pending, stay in IDLE.
- BUSY:
  - If cnt!=0, decrement cnt.
  - If cnt==0:
    - Read: read_data[g] <= mem[addr] and read_ready[g] <= 1.
    - Write: mem[addr] <= data and write_ready[g] <= 1.
    - Set rr_ptr <= (g+1) mod NUM_CONSUMERS, then go to RELAY.
- RELAY:
  - Hold the ready bit.
  - When the matching valid is sampled low, clear ready and go to IDLE.
  - read_data[g] keeps its value until that consumer's next read completes.
- Latency: with no contention, ready rises MEM_LATENCY+1 rising edges after the edge on which valid is first sampled in IDLE.
  - Minimum spacing between the end of one grant and the next grant is 1 cycle, spent in IDLE.
- Request inputs are sampled only at grant. Address or data changes while the request is in BUSY are ignored.
- Valid withdrawn during BUSY: the access still completes and ready still asserts. In RELAY, valid is already low, so ready clears on the next edge.
- Backdoor port: init_we writes mem[init_addr] in any state.
  - If it collides with a completing write to the same address, the backdoor wins.
  - A completing read of the same address returns the old word.
- Address and data are used at full width; no wrap arithmetic is needed. rr_ptr wraps from NUM_CONSUMERS-1 to 0.

Decomposition:
- Shared package gpu_mem_pkg:
  - typedef enum logic[1:0] {IDLE, BUSY, RELAY} mem_resp_state_t
  - typedef enum logic {OP_READ, OP_WRITE} mem_op_t
  - localparam width helpers for grant index and latency counter
- One natural sub-module, rr_arbiter: parameter N; inputs req[N] and ptr; outputs gnt_valid and gnt_idx. Combinational, reused by the global controller.

Test Plan:
- Single read, MEM_LATENCY=2: preload mem[0x10]=0xA5; read_valid[1]=1 with address 0x10 -> read_ready[1] high 3 edges later, read_data[1]=0xA5; drop valid -> ready low next edge.
- Write then read back: consumer 2 writes 0x3C to 0x80 -> write_ready[2] after 3 edges; then consumer 0 reads 0x80 -> 0x3C.
- All 4 consumers read addresses 0..3 (preloaded 0x11..0x44) at the same time -> grants in order 0,1,2,3, each with the correct word; then a second burst starting at rr_ptr=0; consumer 0 re-requesting immediately is served after 1, 2 and 3.
- Reset mid-BUSY on a write of 0x77 to 0x05 (old value 0x00) -> all ready bits 0, busy=0, mem[0x05] still 0x00; after reset release a new read returns 0x00.
- Read and write both valid on consumer 3 -> read served first, then write on a later grant.
- Valid withdrawn during BUSY -> ready pulses exactly one cycle and FSM returns to IDLE.
- Backdoor collision: completing write 0x12 to 0x40 in the same cycle as init_we writing 0x99 to 0x40 -> mem[0x40]=0x99.

Source files
------------

// File: rtl/gpu_mem_pkg.sv
// Shared types and width helpers for the GPU data-memory responder and its controllers.
package gpu_mem_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BUSY  = 2'd1,
    RELAY = 2'd2
  } mem_resp_state_t;

  typedef enum logic {
    OP_READ  = 1'b0,
    OP_WRITE = 1'b1
  } mem_op_t;

  // Latency counter holds MEM_LATENCY-1, and MEM_LATENCY is at most 15
  localparam int CNT_BITS = 4;

  function automatic int idx_bits(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first asserted request at or after ptr, wrapping.
module rr_arbiter #(
  parameter int N  = 4,
  parameter int IW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic          gnt_valid,
  output logic [IW-1:0] gnt_idx
);

  logic [N-1:0] rot_s;
  int unsigned  off_s;
  int unsigned  sum_s;

  // Rotate requests so ptr sits at bit 0, then take the lowest set offset
  always_comb begin
    rot_s     = N'({req, req} >> ptr);
    gnt_valid = 1'b0;
    off_s     = 32'd0;
    for (int k = N - 1; k >= 0; k--) begin
      gnt_valid = gnt_valid | rot_s[k];
      off_s     = rot_s[k] ? 32'(k) : off_s;
    end
    sum_s   = 32'(ptr) + off_s;
    gnt_idx = (sum_s >= 32'(N)) ? IW'(sum_s - 32'(N)) : IW'(sum_s);
  end

endmodule

// File: rtl/gpu_data_mem_responder.sv
// Round-robin responder for per-thread LSU read/write channels in front of a
// single-port word array with fixed access latency and a backdoor preload port.
module gpu_data_mem_responder
  import gpu_mem_pkg::*;
#(
  parameter int NUM_CONSUMERS = 4,
  parameter int ADDR_BITS     = 8,
  parameter int DATA_BITS     = 8,
  parameter int MEM_LATENCY   = 2
) (
  input  logic                                     clk,
  input  logic                                     reset,
  input  logic [NUM_CONSUMERS-1:0]                 read_valid,
  input  logic [NUM_CONSUMERS-1:0][ADDR_BITS-1:0]  read_address,
  output logic [NUM_CONSUMERS-1:0]                 read_ready,
  output logic [NUM_CONSUMERS-1:0][DATA_BITS-1:0]  read_data,
  input  logic [NUM_CONSUMERS-1:0]                 write_valid,
  input  logic [NUM_CONSUMERS-1:0][ADDR_BITS-1:0]  write_address,
  input  logic [NUM_CONSUMERS-1:0][DATA_BITS-1:0]  write_data,
  output logic [NUM_CONSUMERS-1:0]                 write_ready,
  input  logic                                     init_we,
  input  logic [ADDR_BITS-1:0]                     init_addr,
  input  logic [DATA_BITS-1:0]                     init_data,
  output logic                                     busy
);

  localparam int                  IDX_BITS = idx_bits(NUM_CONSUMERS);
  localparam int                  DEPTH    = 1 << ADDR_BITS;
  localparam logic [CNT_BITS-1:0] CNT_INIT = CNT_BITS'(MEM_LATENCY - 1);

  mem_resp_state_t                         state_r, state_s;
  mem_op_t                                 op_r;
  logic [IDX_BITS-1:0]                     rr_ptr_r, gnt_r, arb_idx_s, ptr_next_s;
  logic [ADDR_BITS-1:0]                    addr_r;
  logic [DATA_BITS-1:0]                    wdata_r;
  logic [CNT_BITS-1:0]                     cnt_r;
  logic [NUM_CONSUMERS-1:0]                read_ready_r, write_ready_r, pend_s;
  logic [NUM_CONSUMERS-1:0][DATA_BITS-1:0] read_data_r;
  logic                                    busy_r, arb_valid_s, commit_s, gnt_valid_s;
  logic [DATA_BITS-1:0]                    mem_r [DEPTH];

  assign pend_s      = (read_valid | write_valid) & ~(read_ready_r | write_ready_r);
  assign commit_s    = (state_r == BUSY) && (cnt_r == CNT_BITS'(0));
  assign gnt_valid_s = (op_r == OP_READ) ? read_valid[gnt_r] : write_valid[gnt_r];
  assign ptr_next_s  = (gnt_r == IDX_BITS'(NUM_CONSUMERS - 1)) ? IDX_BITS'(0)
                                                              : gnt_r + IDX_BITS'(1);

  rr_arbiter #(
    .N  (NUM_CONSUMERS),
    .IW (IDX_BITS)
  ) u_arb (
    .req       (pend_s),
    .ptr       (rr_ptr_r),
    .gnt_valid (arb_valid_s),
    .gnt_idx   (arb_idx_s)
  );

  // Next-state logic
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE:    if (arb_valid_s) state_s = BUSY;  else state_s = IDLE;
      BUSY:    if (commit_s)    state_s = RELAY; else state_s = BUSY;
      RELAY:   if (!gnt_valid_s) state_s = IDLE; else state_s = RELAY;
      default: state_s = IDLE;
    endcase
  end

  // Grant latch, latency count, completion and handshake registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r       <= IDLE;
      rr_ptr_r      <= IDX_BITS'(0);
      gnt_r         <= IDX_BITS'(0);
      op_r          <= OP_READ;
      addr_r        <= ADDR_BITS'(0);
      wdata_r       <= DATA_BITS'(0);
      cnt_r         <= CNT_BITS'(0);
      read_ready_r  <= NUM_CONSUMERS'(0);
      write_ready_r <= NUM_CONSUMERS'(0);
      read_data_r   <= '0;
      busy_r        <= 1'b0;
    end else begin
      state_r <= state_s;
      busy_r  <= (state_s != IDLE);
      case (state_r)
        IDLE: begin
          if (arb_valid_s) begin
            gnt_r   <= arb_idx_s;
            wdata_r <= write_data[arb_idx_s];
            cnt_r   <= CNT_INIT;
            // Read wins when both requests of the granted consumer are up
            if (read_valid[arb_idx_s]) begin
              op_r   <= OP_READ;
              addr_r <= read_address[arb_idx_s];
            end else begin
              op_r   <= OP_WRITE;
              addr_r <= write_address[arb_idx_s];
            end
          end
        end
        BUSY: begin
          if (!commit_s) begin
            cnt_r <= cnt_r - CNT_BITS'(1);
          end else begin
            rr_ptr_r <= ptr_next_s;
            if (op_r == OP_READ) begin
              read_data_r[gnt_r]  <= mem_r[addr_r];
              read_ready_r[gnt_r] <= 1'b1;
            end else begin
              write_ready_r[gnt_r] <= 1'b1;
            end
          end
        end
        RELAY: begin
          if (!gnt_valid_s) begin
            read_ready_r  <= NUM_CONSUMERS'(0);
            write_ready_r <= NUM_CONSUMERS'(0);
          end
        end
        default: ;
      endcase
    end
  end

  // Word array; the later backdoor assignment wins an address collision
  always_ff @(posedge clk) begin
    if (commit_s && (op_r == OP_WRITE)) mem_r[addr_r] <= wdata_r;
    if (init_we) mem_r[init_addr] <= init_data;
  end

  assign read_ready  = read_ready_r;
  assign write_ready = write_ready_r;
  assign read_data   = read_data_r;
  assign busy        = busy_r;

endmodule

// File: tb/tb_gpu_data_mem_responder.sv
// Self-checking bench: directed scenarios plus randomized bursts against a
// transaction-level round-robin memory model.
module tb_gpu_data_mem_responder;

  localparam int N   = 4;
  localparam int AB  = 8;
  localparam int DB  = 8;
  localparam int LAT = 2;

  logic                clk = 1'b0;
  logic                reset;
  logic [N-1:0]        read_valid, read_ready, write_valid, write_ready;
  logic [N-1:0][AB-1:0] read_address, write_address;
  logic [N-1:0][DB-1:0] read_data, write_data;
  logic                init_we;
  logic [AB-1:0]       init_addr;
  logic [DB-1:0]       init_data;
  logic                busy;

  gpu_data_mem_responder #(
    .NUM_CONSUMERS (N),
    .ADDR_BITS     (AB),
    .DATA_BITS     (DB),
    .MEM_LATENCY   (LAT)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .read_valid    (read_valid),
    .read_address  (read_address),
    .read_ready    (read_ready),
    .read_data     (read_data),
    .write_valid   (write_valid),
    .write_address (write_address),
    .write_data    (write_data),
    .write_ready   (write_ready),
    .init_we       (init_we),
    .init_addr     (init_addr),
    .init_data     (init_data),
    .busy          (busy)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  logic [DB-1:0] ref_mem [256];
  int            ref_ptr = 0;

  // Per-burst request description: first read, first write, follow-up read
  bit            rd_en [N];
  bit            wr_en [N];
  bit            re_en [N];
  logic [AB-1:0] rd_addr [N];
  logic [AB-1:0] wr_addr [N];
  logic [AB-1:0] re_addr [N];
  logic [DB-1:0] wr_dat [N];

  typedef struct {
    int          idx;
    bit          is_wr;
    logic [DB-1:0] data;
  } comp_t;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic clear_req();
    for (int i = 0; i < N; i++) begin
      rd_en[i] = 1'b0; wr_en[i] = 1'b0; re_en[i] = 1'b0;
      rd_addr[i] = 8'h00; wr_addr[i] = 8'h00; re_addr[i] = 8'h00; wr_dat[i] = 8'h00;
    end
  endtask

  task automatic poke(input logic [AB-1:0] a, input logic [DB-1:0] d);
    init_we = 1'b1; init_addr = a; init_data = d;
    @(negedge clk);
    init_we = 1'b0;
    ref_mem[a] = d;
  endtask

  task automatic pulse_reset();
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    ref_ptr = 0;
  endtask

  // Predict the service order, then drive the handshakes and compare each completion
  task automatic run_burst(input string tag);
    comp_t         exp_q [$];
    comp_t         c;
    bit            prd [N];
    bit            pwr [N];
    bit            pre [N];
    bit            dre [N];
    bit            raise [N];
    logic [AB-1:0] la [N];
    int            p, g, cyc, next_cyc;
    bit            found, rd_fire, wr_fire;

    prd = rd_en; pwr = wr_en; pre = re_en; la = rd_addr;
    p = ref_ptr;
    while (1) begin
      found = 1'b0;
      g = 0;
      for (int k = 0; k < N; k++) begin
        if (!found && (prd[(p + k) % N] || pwr[(p + k) % N])) begin
          found = 1'b1;
          g = (p + k) % N;
        end
      end
      if (!found) break;
      c.idx = g;
      if (prd[g]) begin
        c.is_wr = 1'b0; c.data = ref_mem[la[g]]; prd[g] = 1'b0;
      end else begin
        c.is_wr = 1'b1; c.data = wr_dat[g]; ref_mem[wr_addr[g]] = wr_dat[g]; pwr[g] = 1'b0;
      end
      if (!prd[g] && !pwr[g] && pre[g]) begin
        prd[g] = 1'b1; la[g] = re_addr[g]; pre[g] = 1'b0;
      end
      exp_q.push_back(c);
      p = (g + 1) % N;
    end
    ref_ptr = p;

    dre = re_en;
    for (int i = 0; i < N; i++) begin
      read_valid[i] = rd_en[i]; read_address[i] = rd_addr[i];
      write_valid[i] = wr_en[i]; write_address[i] = wr_addr[i]; write_data[i] = wr_dat[i];
      raise[i] = 1'b0;
    end
    cyc = 0;
    next_cyc = LAT + 1;
    while (exp_q.size() > 0 && cyc < 400) begin
      @(negedge clk);
      cyc++;
      for (int i = 0; i < N; i++) begin
        if (raise[i]) begin
          read_valid[i] = 1'b1; read_address[i] = re_addr[i]; raise[i] = 1'b0;
        end
      end
      for (int i = 0; i < N; i++) begin
        rd_fire = read_ready[i] && read_valid[i];
        wr_fire = write_ready[i] && write_valid[i] && !rd_fire;
        if ((rd_fire || wr_fire) && exp_q.size() > 0) begin
          c = exp_q.pop_front();
          check_eq({tag, "_idx"}, 32'(i), 32'(c.idx));
          check_eq({tag, "_cycle"}, 32'(cyc), 32'(next_cyc));
          check_eq({tag, "_op"}, {31'b0, wr_fire}, {31'b0, c.is_wr});
          next_cyc = cyc + LAT + 2;
          if (rd_fire) begin
            check_eq({tag, "_rdata"}, 32'(read_data[i]), 32'(c.data));
            read_valid[i] = 1'b0;
          end else begin
            write_valid[i] = 1'b0;
          end
          if (!read_valid[i] && !write_valid[i] && dre[i]) begin
            raise[i] = 1'b1; dre[i] = 1'b0;
          end
        end
      end
    end
    if (exp_q.size() != 0) check_eq({tag, "_timeout"}, 32'(exp_q.size()), 32'd0);
    read_valid = 4'b0000; write_valid = 4'b0000;
    @(negedge clk);
    check_eq({tag, "_ready_clr"}, {24'b0, read_ready, write_ready}, 32'd0);
    check_eq({tag, "_idle"}, {31'b0, busy}, 32'd0);
    clear_req();
  endtask

  // Completion edge coincides with a backdoor write to the same address
  task automatic collide(input string tag, input int c, input bit is_wr,
                         input logic [AB-1:0] a, input logic [DB-1:0] d, input logic [DB-1:0] bd);
    logic [DB-1:0] old;
    old = ref_mem[a];
    if (is_wr) begin
      write_valid[c] = 1'b1; write_address[c] = a; write_data[c] = d;
    end else begin
      read_valid[c] = 1'b1; read_address[c] = a;
    end
    @(negedge clk);
    @(negedge clk);
    init_we = 1'b1; init_addr = a; init_data = bd;
    @(negedge clk);
    init_we = 1'b0;
    check_eq({tag, "_ready"}, {31'b0, (is_wr ? write_ready[c] : read_ready[c])}, 32'd1);
    if (!is_wr) check_eq({tag, "_old"}, 32'(read_data[c]), 32'(old));
    read_valid[c] = 1'b0; write_valid[c] = 1'b0;
    @(negedge clk);
    check_eq({tag, "_idle"}, {31'b0, busy}, 32'd0);
    ref_mem[a] = bd;
    ref_ptr = (c + 1) % N;
  endtask

  initial begin
    int hi;
    logic [DB-1:0] seen;
    reset = 1'b0; init_we = 1'b0; init_addr = 8'h00; init_data = 8'h00;
    read_valid = 4'b0000; write_valid = 4'b0000;
    read_address = 32'h0; write_address = 32'h0; write_data = 32'h0;
    clear_req();
    repeat (2) @(negedge clk);
    check_eq("rst_read_ready", 32'(read_ready), 32'd0);
    check_eq("rst_write_ready", 32'(write_ready), 32'd0);
    check_eq("rst_read_data", 32'(read_data), 32'd0);
    check_eq("rst_busy", {31'b0, busy}, 32'd0);
    reset = 1'b1;
    for (int a = 0; a < 256; a++) poke(8'(a), 8'($urandom));

    // Single read, then write and read back
    poke(8'h10, 8'hA5);
    rd_en[1] = 1'b1; rd_addr[1] = 8'h10;
    run_burst("single_rd");
    check_eq("single_rd_hold", 32'(read_data[1]), 32'h0000_00A5);
    wr_en[2] = 1'b1; wr_addr[2] = 8'h80; wr_dat[2] = 8'h3C;
    run_burst("wr_80");
    rd_en[0] = 1'b1; rd_addr[0] = 8'h80;
    run_burst("rd_80");
    check_eq("rd_80_val", 32'(read_data[0]), 32'h0000_003C);

    // All four consumers at once from rr_ptr=0, then a burst with an immediate re-request
    pulse_reset();
    for (int i = 0; i < N; i++) begin
      poke(8'(i), 8'(8'h11 * (i + 1)));
    end
    for (int i = 0; i < N; i++) begin
      rd_en[i] = 1'b1; rd_addr[i] = 8'(i);
    end
    run_burst("all4");
    for (int i = 0; i < N; i++) begin
      rd_en[i] = 1'b1; rd_addr[i] = 8'(3 - i);
    end
    re_en[0] = 1'b1; re_addr[0] = 8'h02;
    run_burst("all4_rereq");

    // Read and write together on consumer 3, same address
    rd_en[3] = 1'b1; rd_addr[3] = 8'h20;
    wr_en[3] = 1'b1; wr_addr[3] = 8'h20; wr_dat[3] = 8'h5A;
    rd_en[1] = 1'b1; rd_addr[1] = 8'h20;
    run_burst("dual");

    // Reset taken in BUSY abandons the pending write
    poke(8'h05, 8'h00);
    write_valid[0] = 1'b1; write_address[0] = 8'h05; write_data[0] = 8'h77;
    @(negedge clk);
    check_eq("rst_mid_busy_pre", {31'b0, busy}, 32'd1);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check_eq("rst_mid_ready", {24'b0, read_ready, write_ready}, 32'd0);
    check_eq("rst_mid_busy", {31'b0, busy}, 32'd0);
    check_eq("rst_mid_rdata", 32'(read_data), 32'd0);
    write_valid[0] = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    ref_ptr = 0;
    rd_en[1] = 1'b1; rd_addr[1] = 8'h05;
    run_burst("rst_rd05");

    // Valid withdrawn in BUSY; address change after grant is ignored
    read_valid[2] = 1'b1; read_address[2] = 8'h30;
    @(negedge clk);
    read_valid[2] = 1'b0; read_address[2] = 8'hCF;
    hi = 0;
    seen = 8'h00;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (read_ready[2]) begin
        hi++;
        seen = read_data[2];
      end
    end
    check_eq("withdraw_pulse", 32'(hi), 32'd1);
    check_eq("withdraw_data", 32'(seen), 32'(ref_mem[8'h30]));
    check_eq("withdraw_idle", {31'b0, busy}, 32'd0);
    ref_ptr = 3;

    // Backdoor collisions with a completing write and a completing read
    collide("bd_wr", 1, 1'b1, 8'h40, 8'h12, 8'h99);
    rd_en[0] = 1'b1; rd_addr[0] = 8'h40;
    run_burst("bd_wr_chk");
    collide("bd_rd", 0, 1'b0, 8'h41, 8'h00, 8'h66);
    rd_en[3] = 1'b1; rd_addr[3] = 8'h41;
    run_burst("bd_rd_chk");

    // Randomized bursts over a narrow address window to force hazards
    for (int b = 0; b < 40; b++) begin
      for (int i = 0; i < N; i++) begin
        rd_en[i]   = 1'($urandom_range(0, 1));
        wr_en[i]   = ($urandom_range(0, 2) == 0);
        re_en[i]   = ($urandom_range(0, 4) == 0);
        rd_addr[i] = 8'($urandom_range(0, 31));
        wr_addr[i] = 8'($urandom_range(0, 31));
        re_addr[i] = 8'($urandom_range(0, 31));
        wr_dat[i]  = 8'($urandom);
      end
      run_burst("rand");
    end

    // Full read-back sweep
    for (int a = 0; a < 256; a += N) begin
      for (int i = 0; i < N; i++) begin
        rd_en[i] = 1'b1; rd_addr[i] = 8'(a + i);
      end
      run_burst("sweep");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
